unit_status_uart: RTL and testbench
===================================

# unit_status_uart

Debug telemetry transmitter for the power-unit control board. It consumes the unit status the board already produces: DC-link voltage, the 12-bit unit error word, and the run/fault/bypass flags. It packs them into a fixed 8-byte frame and sends the frame on the spare serial pin tx2 as 8N1 UART. A frame is sent on a fixed period and also immediately when the error word changes, so a bench PC sees faults without waiting for the next period.

## Interface
Parameters:
- BAUD_DIV, 347, clk cycles per UART bit (40 MHz / 115200); legal range 2..65535
- FRAME_PERIOD_MS, 10, time_1ms pulses between periodic frames; legal range 1..255

Ports:
- clk  in  1  system clock; single clock domain
- Reset  in  1  asynchronous, active-high reset
- time_1ms  in  1  one-clk pulse every 1 ms, from the 1 µs/1 ms divider
- udc_volt  in  12  DC-link voltage code
- err_info  in  12  unit error word
- status  in  4  {BypOk_filtered, BypCon, err_all, start_stop}, bit 3 down to bit 0
- tx2  out  1  UART TX; idles high
- busy  out  1  high while a frame is being shifted
- frame_seq  out  8  sequence number of the last frame started

## Operation
- Frame layout, sent in byte order 0..7:
  - byte0: 0xA5
  - byte1: 0x5A
  - byte2: seq
  - byte3: {status, udc[11:8]}
  - byte4: udc[7:0]
  - byte5: {4'h0, err[11:8]}
  - byte6: err[7:0]
  - byte7: checksum = (byte2+byte3+byte4+byte5+byte6) mod 256
- Each byte is sent 8N1: one start bit (0), then 8 data bits LSB first, then one stop bit (1). Every bit lasts BAUD_DIV clk.
- There is no gap between bytes. The next start bit follows the stop bit directly.
- Period counter:
  - Increments on each time_1ms pulse.
  - On the pulse that brings it to FRAME_PERIOD_MS, it resets to 0 and sets `pending`.
  - It runs independently of frame activity and of event-triggered frames.
- Error-change trigger: `pending` is set in any cycle where err_info ≠ last_err. last_err holds the err value of the most recent frame snapshot; it resets to 0.
- Frame start:
  - Happens in IDLE when `pending` = 1.
  - udc_volt, err_info, status and the checksum are latched in the same edge. last_err is updated to the latched err.
  - seq is incremented: frame_seq = previous value + 1, wrapping 255→0. The first frame after reset carries seq 0x00.
  - `pending` is cleared.
  - Input changes during a frame do not alter the frame being sent.
- Triggers during a frame: they set `pending` (they are not dropped). Multiple triggers collapse into a single following frame.
- Simultaneous period trigger and error change: one frame.
- FSM states:
  - IDLE → START (pending)
  - START → DATA (after BAUD_DIV clk)
  - DATA → STOP (after 8 bits)
  - STOP → START (byte_idx < 7, byte_idx+1) or STOP → IDLE (byte_idx = 7)
- Counters: bit counter 0..BAUD_DIV-1, bit index 0..7, byte index 0..7.

## Timing
- Reset values, applied immediately and asynchronously:
  - tx2 = 1, busy = 0, frame_seq = 0xFF (the first frame increments it to 0x00).
  - pending = 0, last_err = 0, period counter = 0, FSM = IDLE.
- Trigger to line latency:
  - `pending` registers 1 clk after the triggering cycle: the time_1ms pulse cycle, or the first cycle with err mismatch.
  - tx2 falls, busy rises and frame_seq updates 1 clk after that.
  - Total: 2 clk from trigger cycle to start-bit edge.
- Frame length: exactly 80·BAUD_DIV clk from tx2 falling to busy falling. busy falls at the end of byte7's stop bit.
- Back-to-back frames: if `pending` is set at or before busy falls, the next start bit begins 1 clk after busy falls (one IDLE cycle).
- tx2 is a registered output with no combinational path from the inputs.
- Reset asserted mid-frame: the frame is aborted and tx2 goes high at once. On Reset release the block waits in IDLE for a new trigger. A partial frame is never resumed.

## Test plan
All scenarios use BAUD_DIV = 4 and FRAME_PERIOD_MS = 2 unless noted.
1. **Reset:** assert Reset mid-idle -> tx2=1, busy=0, frame_seq=0xFF; no toggling on tx2 for 10 time_1ms pulses with Reset high.
2. **Periodic frame:** udc=0xABC, err=0x000, status=4'b0101, two time_1ms pulses -> tx2 falls 2 clk after the 2nd pulse. Decoded bytes are A5 5A 00 5A BC 00 00 16. busy is high for exactly 320 clk.
3. **Error-change frame:** while idle, err 0x000→0x004 -> frame within 2 clk with byte2=0x01, byte6=0x04, checksum correct. A second frame on an unchanged err occurs only on the period tick.
4. **Change during frame:** err→0x123 mid-frame -> current frame keeps the old err. The next frame starts 1 clk after busy falls with byte5=0x01, byte6=0x23.
5. **Reset mid-byte:** Reset during byte3 data bits -> tx2=1 in the same cycle. After release and one trigger, the frame carries seq 0x00.
6. **Wrap and collapse:**
   - 256 frames -> the 257th carries seq 0x00.
   - A period tick and an err change in the same cycle -> exactly one frame.

Source files
------------

// File: rtl/unit_status_uart.sv
// Debug telemetry UART: packs DC-link voltage, error word and status flags into an 8-byte 8N1 frame on tx2.
// Latency: 2 clk from trigger cycle to start bit; a frame lasts 80*BAUD_DIV clk with no inter-byte gap.
// No backpressure: triggers arriving mid-frame collapse into one pending frame sent right after the current one.
module unit_status_uart #(
    parameter int unsigned BAUD_DIV        = 347,
    parameter int unsigned FRAME_PERIOD_MS = 10
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        time_1ms,
    input  logic [11:0] udc_volt,
    input  logic [11:0] err_info,
    input  logic [3:0]  status,
    output logic        tx2,
    output logic        busy,
    output logic [7:0]  frame_seq
);

    localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
    localparam logic [7:0]  PERIOD_LAST = 8'(FRAME_PERIOD_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Trigger bookkeeping
    logic [7:0]  period_cnt_q;
    logic        pending_q;
    logic [11:0] last_err_q;

    // Frame snapshot, frozen for the whole frame
    logic [7:0]  seq_q;
    logic [11:0] udc_q;
    logic [11:0] err_q;
    logic [3:0]  status_q;
    logic [7:0]  csum_q;

    // Serializer
    state_t      state_q;
    logic [15:0] baud_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [2:0]  byte_idx_q;
    logic        tx2_q;
    logic        busy_q;

    logic        period_hit;
    logic        err_changed;
    logic        start_frame;
    logic        baud_last;
    logic [7:0]  seq_next;
    logic [7:0]  csum_next;
    logic [7:0]  cur_byte;
    logic [2:0]  bit_idx_next;

    assign period_hit   = time_1ms && (period_cnt_q == PERIOD_LAST);
    assign err_changed  = (err_info != last_err_q);
    assign start_frame  = (state_q == S_IDLE) && pending_q;
    assign baud_last    = (baud_cnt_q == BAUD_LAST);
    assign bit_idx_next = bit_idx_q + 3'd1;
    assign seq_next     = seq_q + 8'd1;

    // Checksum covers bytes 2..6 of the frame being started, computed from the live inputs being latched
    assign csum_next = seq_next
                     + {status, udc_volt[11:8]}
                     + udc_volt[7:0]
                     + {4'h0, err_info[11:8]}
                     + err_info[7:0];

    // Select the byte currently on the line from the frozen snapshot
    always_comb begin
        cur_byte = 8'hA5;
        case (byte_idx_q)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = 8'h5A;
            3'd2:    cur_byte = seq_q;
            3'd3:    cur_byte = {status_q, udc_q[11:8]};
            3'd4:    cur_byte = udc_q[7:0];
            3'd5:    cur_byte = {4'h0, err_q[11:8]};
            3'd6:    cur_byte = err_q[7:0];
            3'd7:    cur_byte = csum_q;
            default: cur_byte = 8'hA5;
        endcase
    end

    // Free-running 1 ms period counter, independent of frame activity
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            period_cnt_q <= 8'd0;
        end else if (time_1ms) begin
            period_cnt_q <= period_hit ? 8'd0 : period_cnt_q + 8'd1;
        end
    end

    // Pending request: set by period hit or error change, cleared when a frame starts.
    // At frame start the error word is absorbed by the snapshot, so only a period hit can re-arm it.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pending_q <= 1'b0;
        end else if (start_frame) begin
            pending_q <= period_hit;
        end else if (period_hit || err_changed) begin
            pending_q <= 1'b1;
        end
    end

    // Snapshot inputs, checksum and sequence number on the frame-start edge
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            seq_q      <= 8'hFF;
            udc_q      <= 12'd0;
            err_q      <= 12'd0;
            status_q   <= 4'd0;
            csum_q     <= 8'd0;
            last_err_q <= 12'd0;
        end else if (start_frame) begin
            seq_q      <= seq_next;
            udc_q      <= udc_volt;
            err_q      <= err_info;
            status_q   <= status;
            csum_q     <= csum_next;
            last_err_q <= err_info;
        end
    end

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit, back-to-back for 8 bytes
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            tx2_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx2_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (pending_q) begin
                        state_q    <= S_START;
                        tx2_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        baud_cnt_q <= 16'd0;
                        bit_idx_q  <= 3'd0;
                        byte_idx_q <= 3'd0;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt_q <= 16'd0;
                        bit_idx_q  <= 3'd0;
                        tx2_q      <= cur_byte[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt_q <= 16'd0;
                        if (bit_idx_q == 3'd7) begin
                            tx2_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_next;
                            tx2_q     <= cur_byte[bit_idx_next];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt_q <= 16'd0;
                        if (byte_idx_q == 3'd7) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            tx2_q   <= 1'b1;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            tx2_q      <= 1'b0;
                            state_q    <= S_START;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx2_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx2       = tx2_q;
    assign busy      = busy_q;
    assign frame_seq = seq_q;

endmodule

// File: tb/tb_unit_status_uart.sv
// Bench for unit_status_uart: bit-stream model compared every cycle plus directed frame decodes.
// Main DUT at BAUD_DIV=4 / FRAME_PERIOD_MS=2; a second fast instance exercises sequence wrap.
// Stimulus changes 1 time unit after posedge; model steps on posedge; comparison on negedge.
module tb_unit_status_uart;

    localparam int BD   = 4;
    localparam int FP   = 2;
    localparam int FLEN = 80 * BD;

    logic        clk = 1'b0;
    logic        Reset;
    logic        time_1ms;
    logic [11:0] udc_volt;
    logic [11:0] err_info;
    logic [3:0]  status;
    logic        tx2;
    logic        busy;
    logic [7:0]  frame_seq;

    logic        time2;
    logic [11:0] udc2;
    logic [11:0] err2;
    logic [3:0]  status2;
    logic        tx2_b;
    logic        busy_b;
    logic [7:0]  seq_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [7:0] cap_b [8];
    int         cap_wait;
    int         cap_busy;

    logic [7:0] exp2 [8] = '{8'hA5, 8'h5A, 8'h00, 8'h5A, 8'hBC, 8'h00, 8'h00, 8'h16};

    always #5 clk = ~clk;

    unit_status_uart #(.BAUD_DIV(BD), .FRAME_PERIOD_MS(FP)) u_dut (
        .clk(clk), .Reset(Reset), .time_1ms(time_1ms), .udc_volt(udc_volt),
        .err_info(err_info), .status(status), .tx2(tx2), .busy(busy), .frame_seq(frame_seq)
    );

    unit_status_uart #(.BAUD_DIV(2), .FRAME_PERIOD_MS(1)) u_dut2 (
        .clk(clk), .Reset(Reset), .time_1ms(time2), .udc_volt(udc2),
        .err_info(err2), .status(status2), .tx2(tx2_b), .busy(busy_b), .frame_seq(seq_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model: frame = queue of line levels, one per clk ----------------
    bit         m_line [$];
    bit         m_pend;
    int         m_cnt;
    logic [11:0] m_last_err;
    logic [7:0] m_seq;
    logic       e_tx;
    logic       e_busy;

    always @(posedge clk or posedge Reset) begin
        logic       hit;
        logic [7:0] fb [8];
        if (Reset) begin
            m_line.delete();
            m_pend     = 1'b0;
            m_cnt      = 0;
            m_last_err = 12'd0;
            m_seq      = 8'hFF;
            e_tx       = 1'b1;
            e_busy     = 1'b0;
        end else begin
            hit = 1'b0;
            if (time_1ms) begin
                if (m_cnt + 1 == FP) begin
                    m_cnt = 0;
                    hit   = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (!e_busy && m_pend) begin
                m_seq = m_seq + 8'd1;
                fb[0] = 8'hA5;
                fb[1] = 8'h5A;
                fb[2] = m_seq;
                fb[3] = {status, udc_volt[11:8]};
                fb[4] = udc_volt[7:0];
                fb[5] = {4'h0, err_info[11:8]};
                fb[6] = err_info[7:0];
                fb[7] = fb[2] + fb[3] + fb[4] + fb[5] + fb[6];
                for (int i = 0; i < 8; i++) begin
                    for (int r = 0; r < BD; r++) m_line.push_back(1'b0);
                    for (int j = 0; j < 8; j++)
                        for (int r = 0; r < BD; r++) m_line.push_back(fb[i][j]);
                    for (int r = 0; r < BD; r++) m_line.push_back(1'b1);
                end
                m_pend     = hit;
                m_last_err = err_info;
                e_tx       = m_line.pop_front();
                e_busy     = 1'b1;
            end else begin
                if (hit || (err_info != m_last_err)) m_pend = 1'b1;
                if (m_line.size() > 0) begin
                    e_tx   = m_line.pop_front();
                    e_busy = 1'b1;
                end else begin
                    e_tx   = 1'b1;
                    e_busy = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_tx2", tx2, e_tx);
            check("cyc_busy", busy, e_busy);
            check("cyc_seq", frame_seq, m_seq);
        end
    end

    // ---------------- helpers (called at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        time_1ms = 1'b1;
        tick();
        time_1ms = 1'b0;
    endtask

    // Waits for tx2 to fall, samples one whole frame plus one cycle, decodes mid-bit samples.
    task automatic capture(input int limit);
        bit s [FLEN];
        int n;
        n        = 0;
        cap_busy = 0;
        do begin
            tick();
            n++;
        end while (tx2 !== 1'b0 && n < limit);
        cap_wait = n;
        if (tx2 !== 1'b0) begin
            check("frame_start_seen", tx2, 0);
            for (int i = 0; i < 8; i++) cap_b[i] = 8'hXX;
            return;
        end
        for (int k = 0; k < FLEN; k++) begin
            if (k > 0) tick();
            s[k] = tx2;
            if (busy) cap_busy++;
        end
        tick();
        if (busy) cap_busy++;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                cap_b[i][j] = s[(i * 10 + 1 + j) * BD + BD / 2];
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_seen;
        int frames;
        int cyc;
        bit prev;

        Reset    = 1'b1;
        time_1ms = 1'b0;
        udc_volt = 12'hABC;
        err_info = 12'h000;
        status   = 4'b0101;
        time2    = 1'b0;
        udc2     = 12'h123;
        err2     = 12'h000;
        status2  = 4'h0;
        repeat (3) tick();
        check("rst_tx2", tx2, 1);
        check("rst_busy", busy, 0);
        check("rst_seq", frame_seq, 8'hFF);
        chk_en = 1'b1;
        Reset  = 1'b0;
        repeat (5) tick();

        // 1: reset mid-idle, ten pulses while held
        Reset = 1'b1;
        #1;
        check("t1_tx2", tx2, 1);
        check("t1_busy", busy, 0);
        check("t1_seq", frame_seq, 8'hFF);
        repeat (10) begin
            pulse();
            tick();
            check("t1_tx2_quiet", tx2, 1);
        end
        tick();
        Reset = 1'b0;
        repeat (3) tick();

        // 2: periodic frame after two pulses
        pulse();
        repeat (3) tick();
        check("t2_no_frame_one_pulse", busy, 0);
        time_1ms = 1'b1;
        fork
            capture(20);
            begin tick(); time_1ms = 1'b0; end
        join
        check("t2_latency", cap_wait, 2);
        for (int i = 0; i < 8; i++) check("t2_byte", cap_b[i], exp2[i]);
        check("t2_busy_len", cap_busy, FLEN);
        repeat (5) tick();

        // 3: error-change frame, then no frame until the period completes
        err_info = 12'h004;
        capture(20);
        check("t3_latency", cap_wait, 2);
        check("t3_seq_byte", cap_b[2], 8'h01);
        check("t3_err_lo", cap_b[6], 8'h04);
        check("t3_csum", cap_b[7], 8'h1B);
        pulse();
        repeat (20) tick();
        check("t3_no_frame_same_err", busy, 0);

        // 4: period frame with err change mid-frame, then back-to-back follow-up
        time_1ms = 1'b1;
        fork
            capture(20);
            begin
                tick();
                time_1ms = 1'b0;
                repeat (100) tick();
                err_info = 12'h123;
            end
        join
        check("t4_seq_byte", cap_b[2], 8'h02);
        check("t4_old_err_hi", cap_b[5], 8'h00);
        check("t4_old_err_lo", cap_b[6], 8'h04);
        capture(20);
        check("t4_b2b_gap", cap_wait, 1);
        check("t4_next_seq", cap_b[2], 8'h03);
        check("t4_new_err_hi", cap_b[5], 8'h01);
        check("t4_new_err_lo", cap_b[6], 8'h23);
        check("t4_new_csum", cap_b[7], 8'h3D);
        repeat (5) tick();

        // 5: reset during byte3 data bits
        pulse();
        pulse();
        cyc = 0;
        while (tx2 !== 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t5_frame_started", tx2, 0);
        repeat (130) tick();
        check("t5_mid_frame_busy", busy, 1);
        Reset = 1'b1;
        #1;
        check("t5_rst_tx2", tx2, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_seq", frame_seq, 8'hFF);
        repeat (3) tick();
        Reset = 1'b0;
        capture(20);
        check("t5_latency", cap_wait, 2);
        check("t5_seq_byte", cap_b[2], 8'h00);
        check("t5_frame_seq", frame_seq, 8'h00);
        check("t5_err_lo", cap_b[6], 8'h23);
        repeat (5) tick();

        // 6b: period tick and err change in the same cycle give one frame
        pulse();
        repeat (5) tick();
        time_1ms = 1'b1;
        err_info = 12'h777;
        fork
            capture(20);
            begin tick(); time_1ms = 1'b0; end
        join
        check("t6_latency", cap_wait, 2);
        check("t6_seq_byte", cap_b[2], 8'h01);
        check("t6_err_hi", cap_b[5], 8'h07);
        check("t6_err_lo", cap_b[6], 8'h77);
        busy_seen = 0;
        repeat (60) begin
            tick();
            if (busy) busy_seen++;
        end
        check("t6_single_frame", busy_seen, 0);

        // 6a: sequence wrap on the fast instance, err changing every cycle
        frames = 0;
        cyc    = 0;
        prev   = 1'b0;
        while (frames < 257 && cyc < 60000) begin
            tick();
            cyc++;
            err2 = err2 + 12'd1;
            if (busy_b && !prev) begin
                check("wrap_seq", seq_b, 32'(frames[7:0]));
                frames++;
            end
            prev = busy_b;
        end
        check("wrap_frame_count", frames, 257);
        check("wrap_257th_seq", seq_b, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
